// File: rtl/mul_booth_csa_iter_if.sv
// Handshake and result bundle between Ex and the iterative Booth/CSA multiplier front end.
// Master is the Ex side; slave is the multiplier.
interface mul_booth_csa_iter_if #(
  parameter int DATA_WIDTH = 64
);
  logic                      MulStart;
  logic                      MulFlush;
  logic [1:0]                MulOp;
  logic [DATA_WIDTH-1:0]     MultiplicandIn;
  logic [DATA_WIDTH-1:0]     MultiplierIn;
  logic                      MulBusy;
  logic [1:0]                MulHoldFlag;
  logic                      PPValid;
  logic [2*DATA_WIDTH-1:0]   SumPP;
  logic [2*DATA_WIDTH-1:0]   CarryPP;

  modport master (
    output MulStart, MulFlush, MulOp, MultiplicandIn, MultiplierIn,
    input  MulBusy, MulHoldFlag, PPValid, SumPP, CarryPP
  );

  modport slave (
    input  MulStart, MulFlush, MulOp, MultiplicandIn, MultiplierIn,
    output MulBusy, MulHoldFlag, PPValid, SumPP, CarryPP
  );
endinterface

// File: rtl/mul_booth_csa_iter.sv
// Iterative radix-4 Booth partial-product generator feeding a 3:2 carry-save accumulator.
// One Booth digit per cycle, then a fold step that adds the deferred +1 negation bits.
module mul_booth_csa_iter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_booth_csa_iter_if.slave bus
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int EW = DATA_WIDTH + 2;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ITER, FOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mcand_q, mplier_q;
  logic [PW-1:0]   sum_q, carry_q, neg_q;
  logic [CW-1:0]   cnt_q;

  logic            start_ok, m_sign, y_sign;
  logic [CW:0]     shamt;
  logic [EW:0]     y_window;
  logic [2:0]      triple;
  logic            dig_zero, dig_neg, dig_two;
  logic [PW-1:0]   mext, x_mag, pp_iter, neg_set, pp, csa_sum, csa_carry;

  assign start_ok = bus.MulStart && !bus.MulFlush;
  assign m_sign   = (bus.MulOp != 2'b11) && bus.MultiplicandIn[DATA_WIDTH-1];
  assign y_sign   = !bus.MulOp[1] && bus.MultiplierIn[DATA_WIDTH-1];

  // Digit i looks at Yext[2i+1:2i-1]; the appended zero supplies Yext[-1].
  assign shamt    = {cnt_q, 1'b0};
  assign y_window = {mplier_q, 1'b0};
  assign triple   = y_window[shamt +: 3];

  always_comb begin
    dig_zero = 1'b0;
    dig_neg  = 1'b0;
    dig_two  = 1'b0;
    case (triple)
      3'b001, 3'b010: ;
      3'b011:         dig_two = 1'b1;
      3'b100:         begin dig_neg = 1'b1; dig_two = 1'b1; end
      3'b101, 3'b110: dig_neg = 1'b1;
      default:        dig_zero = 1'b1;
    endcase
  end

  // Negative digits use the one's complement here; the +1 is collected in neg_q.
  assign mext    = {{(PW-EW){mcand_q[EW-1]}}, mcand_q};
  assign x_mag   = dig_two ? (mext << 1) : mext;
  assign pp_iter = dig_zero ? '0 : ((dig_neg ? ~x_mag : x_mag) << shamt);
  assign neg_set = {{(PW-1){1'b0}}, (!dig_zero && dig_neg)} << shamt;

  assign pp        = (state_q == FOLD) ? neg_q : pp_iter;
  assign csa_sum   = sum_q ^ carry_q ^ pp;
  assign csa_carry = ((sum_q & carry_q) | (sum_q & pp) | (carry_q & pp)) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = ITER;
      ITER: begin
        if (bus.MulFlush)       state_d = IDLE;
        else if (cnt_q == LAST) state_d = FOLD;
      end
      FOLD:    state_d = bus.MulFlush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      neg_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_ok) begin
          mcand_q  <= {{2{m_sign}}, bus.MultiplicandIn};
          mplier_q <= {{2{y_sign}}, bus.MultiplierIn};
          sum_q    <= '0;
          carry_q  <= '0;
          neg_q    <= '0;
          cnt_q    <= '0;
        end
        ITER: if (!bus.MulFlush) begin
          sum_q   <= csa_sum;
          carry_q <= csa_carry;
          neg_q   <= neg_q | neg_set;
          cnt_q   <= cnt_q + 1'b1;
        end
        FOLD: if (!bus.MulFlush) begin
          sum_q   <= csa_sum;
          carry_q <= csa_carry;
        end
        default: ;
      endcase
    end
  end

  assign bus.MulBusy     = (state_q == ITER) || (state_q == FOLD);
  assign bus.PPValid     = (state_q == DONE);
  assign bus.MulHoldFlag = bus.MulBusy ? 2'b10 : (bus.PPValid ? 2'b01 : 2'b00);
  assign bus.SumPP       = sum_q;
  assign bus.CarryPP     = carry_q;
endmodule

// File: tb/tb_mul_booth_csa_iter.sv
// Directed-vector bench for mul_booth_csa_iter: products, timing, flush, overlap and reset.
module tb_mul_booth_csa_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  mul_booth_csa_iter_if #(.DATA_WIDTH(64)) bus ();

  mul_booth_csa_iter #(.DATA_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation from its start edge E0; observation index e means "after edge E0+e".
  task automatic applyStimulus(
    input  logic [1:0]   op,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  int           flush_at,
    input  int           restart_at,
    output logic [127:0] prod,
    output int           v_edge,
    output int           v_cnt,
    output int           flag_bad,
    output logic [1:0]   flag_after_flush,
    output logic         busy_after_flush
  );
    logic [1:0] exp_flag;
    prod = '0; v_edge = -1; v_cnt = 0; flag_bad = 0;
    flag_after_flush = 2'b11; busy_after_flush = 1'b1;
    @(negedge clk);
    bus.MulOp = op; bus.MultiplicandIn = a; bus.MultiplierIn = b; bus.MulStart = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= 45; e++) begin
      @(negedge clk);
      exp_flag = (e <= 33) ? 2'b10 : ((e == 34) ? 2'b01 : 2'b00);
      if (flush_at < 0 && bus.MulHoldFlag !== exp_flag) flag_bad++;
      if (flush_at >= 0 && e == flush_at + 1) begin
        flag_after_flush = bus.MulHoldFlag;
        busy_after_flush = bus.MulBusy;
      end
      if (bus.PPValid === 1'b1) begin
        v_cnt++;
        v_edge = e;
        prod = bus.SumPP + bus.CarryPP;
      end
      bus.MulStart = (e == restart_at);
      bus.MulFlush = (e == flush_at);
      bus.MulOp = (e == restart_at) ? 2'b00 : op;
      bus.MultiplicandIn = 64'hA5A5_5A5A_DEAD_BEEF;
      bus.MultiplierIn   = 64'h1234_5678_9ABC_DEF1;
    end
    bus.MulStart = 1'b0;
    bus.MulFlush = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [1:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [127:0] expected, input int restart_at);
    logic [127:0] prod;
    int v_edge, v_cnt, flag_bad;
    logic [1:0] ff;
    logic fb;
    applyStimulus(op, a, b, -1, restart_at, prod, v_edge, v_cnt, flag_bad, ff, fb);
    checkOutput({tag, "_product"}, prod, expected);
    checkOutput({tag, "_valid_edge"}, 128'(v_edge), 128'd34);
    checkOutput({tag, "_valid_count"}, 128'(v_cnt), 128'd1);
    checkOutput({tag, "_flag_seq"}, 128'(flag_bad), 128'd0);
  endtask

  initial begin
    logic [127:0] prod;
    int v_edge, v_cnt, flag_bad;
    logic [1:0] ff;
    logic fb;

    rst_n = 1'b0;
    bus.MulStart = 1'b0; bus.MulFlush = 1'b0; bus.MulOp = 2'b00;
    bus.MultiplicandIn = '0; bus.MultiplierIn = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",  128'(bus.MulBusy), 128'd0);
    checkOutput("rst_flag",  128'(bus.MulHoldFlag), 128'd0);
    checkOutput("rst_valid", 128'(bus.PPValid), 128'd0);
    checkOutput("rst_sum",   bus.SumPP, 128'd0);
    checkOutput("rst_carry", bus.CarryPP, 128'd0);
    rst_n = 1'b1;

    runVector("mul_3x5",       2'b00, 64'd3, 64'd5, 128'd15, -1);
    runVector("mulh_m1xm1",    2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1, -1);
    runVector("mulhu_max",     2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, -1);
    runVector("mulhsu_m1xmax", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, -1);
    runVector("mulh_minsq",    2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              128'h4000_0000_0000_0000_0000_0000_0000_0000, -1);
    runVector("mul_m7x6",      2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, -1);
    runVector("mulhu_2p63x2",  2'b11, 64'h8000_0000_0000_0000, 64'd2,
              128'h0000_0000_0000_0001_0000_0000_0000_0000, -1);

    // A start request mid-operation must not re-latch the operands.
    runVector("restart_ignored", 2'b11, 64'h10, 64'h20, 128'h200, 5);

    // Flush raised during the 10th ITER cycle.
    applyStimulus(2'b00, 64'd3, 64'd5, 9, -1, prod, v_edge, v_cnt, flag_bad, ff, fb);
    checkOutput("flush_busy",  128'(fb), 128'd0);
    checkOutput("flush_flag",  128'(ff), 128'd0);
    checkOutput("flush_no_valid", 128'(v_cnt), 128'd0);

    // Flush and start together in IDLE: the start is dropped.
    @(negedge clk);
    bus.MulOp = 2'b00; bus.MultiplicandIn = 64'd3; bus.MultiplierIn = 64'd5;
    bus.MulStart = 1'b1; bus.MulFlush = 1'b1;
    @(negedge clk);
    bus.MulStart = 1'b0; bus.MulFlush = 1'b0;
    checkOutput("flush_start_busy", 128'(bus.MulBusy), 128'd0);
    checkOutput("flush_start_flag", 128'(bus.MulHoldFlag), 128'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.MulOp = 2'b11; bus.MultiplicandIn = 64'hFFFF_FFFF_FFFF_FFFF; bus.MultiplierIn = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.MulStart = 1'b1;
    @(negedge clk);
    bus.MulStart = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("pre_rst_busy", 128'(bus.MulBusy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",  128'(bus.MulBusy), 128'd0);
    checkOutput("midrst_flag",  128'(bus.MulHoldFlag), 128'd0);
    checkOutput("midrst_valid", 128'(bus.PPValid), 128'd0);
    checkOutput("midrst_sum",   bus.SumPP, 128'd0);
    checkOutput("midrst_carry", bus.CarryPP, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runVector("post_rst_mul", 2'b00, 64'd7, 64'd9, 128'd63, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
